// File: rtl/horner_feeder_if.sv
// Handshake bundle between the sample source, horner_feeder and mac.
// master drives samples and beat-ready; slave is the feeder.
interface horner_feeder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] sig_o;
  logic [DATA_WIDTH-1:0] coeff_o;
  logic                  first_o;
  logic                  last_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  done_o;

  modport master (
    output in_valid_i, in_data_i, ready_i,
    input  in_ready_o, valid_o, sig_o, coeff_o,
    input  first_o, last_o, full_o, empty_o, done_o
  );

  modport slave (
    input  in_valid_i, in_data_i, ready_i,
    output in_ready_o, valid_o, sig_o, coeff_o,
    output first_o, last_o, full_o, empty_o, done_o
  );
endinterface

// File: rtl/horner_feeder.sv
// Sample FIFO feeding mac: per sample, emits the exp() Taylor
// coefficients highest order first; a NaN word ends the stream.
module horner_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5,
  parameter int N_COEFF    = 11
) (
  input logic clk_i,
  input logic rst_i,
  horner_feeder_if.slave io
);
  localparam int DEPTH = 1 << ADDR_LINES;
  localparam int KW    = $clog2(N_COEFF);
  localparam int CW    = ADDR_LINES + 1;

  localparam logic [CW-1:0] C1     = 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [ADDR_LINES-1:0] P1 = 1;
  localparam logic [KW-1:0] K1 = 1;
  localparam logic [KW-1:0] KL = KW'(N_COEFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  function automatic logic [31:0] rom(
    input logic [KW-1:0] k
  );
    case (k)
      4'd0:    rom = 32'h3493F27D;
      4'd1:    rom = 32'h3638EF1D;
      4'd2:    rom = 32'h37D00D01;
      4'd3:    rom = 32'h39500D01;
      4'd4:    rom = 32'h3AB60B61;
      4'd5:    rom = 32'h3C088889;
      4'd6:    rom = 32'h3D2AAAAB;
      4'd7:    rom = 32'h3E2AAAAB;
      4'd8:    rom = 32'h3F000000;
      4'd9:    rom = 32'h3F800000;
      4'd10:   rom = 32'h3F800000;
      default: rom = 32'h0;
    endcase
  endfunction

  // NaN of either sign; infinity stays ordinary data.
  function automatic logic is_term(
    input logic [DATA_WIDTH-1:0] w
  );
    is_term = (w[30:23] == 8'hFF) && (w[22:0] != 23'h0);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_LINES-1:0] wr_ptr;
  logic [ADDR_LINES-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  closed_q;

  state_t                state;
  logic [KW-1:0]         k;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] sig_q;
  logic [DATA_WIDTH-1:0] coeff_q;
  logic                  first_q;
  logic                  last_q;
  logic                  done_q;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  assign io.in_ready_o = !full_q && !closed_q;
  assign push = io.in_valid_i && io.in_ready_o;
  assign pop  = (state == IDLE) && !empty_q;
  assign head = mem[rd_ptr];

  assign io.valid_o = valid_q;
  assign io.sig_o   = sig_q;
  assign io.coeff_o = coeff_q;
  assign io.first_o = first_q;
  assign io.last_o  = last_q;
  assign io.full_o  = full_q;
  assign io.empty_o = empty_q;
  assign io.done_o  = done_q;

  // Occupancy after this edge; simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + C1;
    end else if (pop && !push) begin
      count_nxt = count - C1;
    end
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= io.in_data_i;
    end
  end

  // FIFO pointers, occupancy flags and the stream-closed latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      closed_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + P1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + P1;
      end
      count   <= count_nxt;
      full_q  <= (count_nxt == C_FULL);
      empty_q <= (count_nxt == '0);
      if (push && is_term(io.in_data_i)) begin
        closed_q <= 1'b1;
      end
    end
  end

  // Beat sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      k       <= '0;
      valid_q <= 1'b0;
      sig_q   <= '0;
      coeff_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty_q) begin
            k <= '0;
            if (is_term(head)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= ISSUE;
              valid_q <= 1'b1;
              sig_q   <= head;
              coeff_q <= rom('0);
              first_q <= 1'b1;
              last_q  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (io.ready_i) begin
            if (k == KL) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              k       <= k + K1;
              coeff_q <= rom(k + K1);
              first_q <= 1'b0;
              last_q  <= ((k + K1) == KL);
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_horner_feeder.sv
// Directed bench for horner_feeder: beat order, stalls,
// FIFO fill/wrap, terminator handling and mid-stream reset.
module tb_horner_feeder;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  horner_feeder_if #(.DATA_WIDTH(32)) bus ();

  horner_feeder #(
    .DATA_WIDTH(32),
    .ADDR_LINES(5),
    .N_COEFF(11)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io(bus)
  );

  typedef struct packed {
    logic [31:0] sig;
    logic [31:0] coeff;
    logic        first;
    logic        last;
  } beat_t;

  typedef struct {
    logic        rdy;
    logic        vld;
    logic        fst;
    logic        lst;
    logic [31:0] coeff;
  } vec_t;

  logic [31:0] rom_c [11] = '{
    32'h3493F27D, 32'h3638EF1D, 32'h37D00D01,
    32'h39500D01, 32'h3AB60B61, 32'h3C088889,
    32'h3D2AAAAB, 32'h3E2AAAAB, 32'h3F000000,
    32'h3F800000, 32'h3F800000
  };

  beat_t       beats [$];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    beat_t b;
    if (!rst && bus.valid_o && bus.ready_i) begin
      b.sig   = bus.sig_o;
      b.coeff = bus.coeff_o;
      b.first = bus.first_o;
      b.last  = bus.last_o;
      beats.push_back(b);
    end
  end

  task automatic chk(input string nm,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    cyc(2);
    rst = 1'b0;
    beats.delete();
    exp_q.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    logic acc;
    bit ok;
    ok = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = w;
    for (int i = 0; i < 2000; i++) begin
      acc = bus.in_ready_o;
      cyc(1);
      if (acc) begin
        ok = 1;
        break;
      end
    end
    bus.in_valid_i = 1'b0;
    if (!ok) chk("push_timeout", 72'd0, 72'd1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (beats.size() >= n) break;
      cyc(1);
    end
    if (beats.size() < n) chk("beat_timeout", 72'(beats.size()), 72'(n));
  endtask

  task automatic check_beats(input string nm);
    int idx;
    beat_t e;
    chk({nm, "_count"}, 72'(beats.size()), 72'(exp_q.size() * 11));
    idx = 0;
    for (int s = 0; s < exp_q.size(); s++) begin
      for (int k = 0; k < 11; k++) begin
        e.sig   = exp_q[s];
        e.coeff = rom_c[k];
        e.first = (k == 0);
        e.last  = (k == 10);
        if (idx < beats.size()) begin
          chk({nm, "_beat"}, 72'(beats[idx]), 72'(e));
        end
        idx++;
      end
    end
    beats.delete();
    exp_q.delete();
  endtask

  vec_t tab [14];
  int   acc_n;
  logic acc;
  logic [31:0] w;

  initial begin
    tab = '{
      '{1'b1, 1'b1, 1'b1, 1'b0, 32'h3493F27D},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3638EF1D},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h37D00D01},
      '{1'b0, 1'b1, 1'b0, 1'b0, 32'h39500D01},
      '{1'b0, 1'b1, 1'b0, 1'b0, 32'h39500D01},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h39500D01},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3AB60B61},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3C088889},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3D2AAAAB},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3E2AAAAB},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3F000000},
      '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3F800000},
      '{1'b1, 1'b1, 1'b0, 1'b1, 32'h3F800000},
      '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000}
    };

    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.ready_i    = 1'b1;

    // reset state
    do_reset();
    chk("rst_valid", 72'(bus.valid_o), 72'd0);
    chk("rst_flags",
        72'({bus.first_o, bus.last_o, bus.full_o,
             bus.empty_o, bus.done_o, bus.in_ready_o}),
        72'(6'b000101));
    chk("rst_data", 72'({bus.sig_o, bus.coeff_o}), 72'd0);

    // single sample at full rate
    bus.ready_i = 1'b1;
    push_word(32'hC0A00000);
    exp_q.push_back(32'hC0A00000);
    wait_beats(11, 100);
    chk("t1_bubble_valid", 72'(bus.valid_o), 72'd0);
    chk("t1_empty", 72'(bus.empty_o), 72'd1);
    cyc(5);
    check_beats("t1");

    // ready stall during beats 3-5, cycle by cycle
    do_reset();
    bus.ready_i = 1'b1;
    push_word(32'hC0A00000);
    exp_q.push_back(32'hC0A00000);
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      chk($sformatf("t2_cyc%0d", i),
          72'({bus.valid_o, bus.first_o, bus.last_o,
               tab[i].vld ? bus.coeff_o : 32'h0}),
          72'({tab[i].vld, tab[i].fst, tab[i].lst,
               tab[i].coeff}));
      bus.ready_i = tab[i].rdy;
    end
    bus.ready_i = 1'b1;
    cyc(3);
    check_beats("t2");

    // fill with mac stalled, then drain across pointer wrap
    do_reset();
    bus.ready_i = 1'b0;
    acc_n = 0;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = 32'h40000000 | 32'(acc_n);
      bus.in_data_i = w;
      acc = bus.in_ready_o;
      cyc(1);
      if (acc) begin
        exp_q.push_back(w);
        acc_n++;
      end
    end
    bus.in_valid_i = 1'b0;
    chk("t3_accepted", 72'(acc_n), 72'd33);
    chk("t3_full", 72'(bus.full_o), 72'd1);
    chk("t3_in_ready", 72'(bus.in_ready_o), 72'd0);
    bus.ready_i = 1'b1;
    wait_beats(363, 1000);
    cyc(3);
    chk("t3_empty", 72'(bus.empty_o), 72'd1);
    check_beats("t3");

    // 30 samples then a NaN terminator
    do_reset();
    bus.ready_i = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (n == 0) w = 32'hC0A00000;
      else if (n == 29) w = 32'h40A00000;
      else w = 32'h3F000000 + 32'(n << 8);
      push_word(w);
      exp_q.push_back(w);
    end
    push_word(32'h7F900000);
    chk("t4_closed", 72'(bus.in_ready_o), 72'd0);
    wait_beats(330, 1500);
    cyc(4);
    chk("t4_done", 72'(bus.done_o), 72'd1);
    chk("t4_valid", 72'(bus.valid_o), 72'd0);
    chk("t4_in_ready", 72'(bus.in_ready_o), 72'd0);
    cyc(10);
    chk("t4_valid_late", 72'(bus.valid_o), 72'd0);
    check_beats("t4");

    // reset in the middle of a sample
    do_reset();
    bus.ready_i = 1'b1;
    for (int n = 0; n < 5; n++) push_word(32'h3F800000 + 32'(n));
    for (int i = 0; i < 50; i++) begin
      if (bus.valid_o && bus.coeff_o == rom_c[5]) break;
      cyc(1);
    end
    chk("t5_at_beat5",
        72'({bus.valid_o, bus.coeff_o}),
        72'({1'b1, 32'h3C088889}));
    chk("t5_queued", 72'(bus.empty_o), 72'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t5_after_rst",
        72'({bus.valid_o, bus.empty_o, bus.done_o}),
        72'(3'b010));
    beats.delete();
    exp_q.delete();
    push_word(32'h40400000);
    exp_q.push_back(32'h40400000);
    wait_beats(11, 100);
    cyc(5);
    check_beats("t5");

    // infinity is data, quiet negative NaN terminates
    do_reset();
    bus.ready_i = 1'b1;
    push_word(32'h7F800000);
    exp_q.push_back(32'h7F800000);
    push_word(32'hFFC00000);
    wait_beats(11, 100);
    cyc(5);
    chk("t6_done", 72'(bus.done_o), 72'd1);
    chk("t6_valid", 72'(bus.valid_o), 72'd0);
    check_beats("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
